// File: rtl/dual_issue_ctrl.sv
// rtl/dual_issue_ctrl.sv - dual-issue pairing/split controller; optional stats counters under ISSUE_STATS_EN
module dual_issue_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr1_in,
    input  logic [31:0] instr2_in,
    input  logic        valid_in,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] slot0_pc,
    output logic [31:0] slot0_instr,
    output logic        slot0_valid,
    output logic [31:0] slot1_pc,
    output logic [31:0] slot1_instr,
    output logic        slot1_valid
`ifdef ISSUE_STATS_EN
    ,
    output logic [CNT_W-1:0] pair_cnt,
    output logic [CNT_W-1:0] split_cnt
`endif
);

    typedef enum logic {ST_PAIR, ST_SECOND} state_t;

    typedef struct packed {
        logic [4:0] dst;
        logic       rs_rd;
        logic       rt_rd;
        logic       mem;
        logic       ctl;
    } dec_t;

    function automatic dec_t f_dec(input logic [31:0] ins);
        dec_t d;
        d = '0;
        case (ins[31:26])
            6'd0: begin
                if (ins[5:0] == 6'h08) begin
                    d.ctl   = 1'b1;
                    d.rs_rd = 1'b1;
                end else begin
                    d.dst   = ins[15:11];
                    d.rs_rd = 1'b1;
                    d.rt_rd = 1'b1;
                end
            end
            6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15: begin
                d.dst   = ins[20:16];
                d.rs_rd = 1'b1;
            end
            6'd35: begin
                d.dst   = ins[20:16];
                d.rs_rd = 1'b1;
                d.mem   = 1'b1;
            end
            6'd43: begin
                d.rs_rd = 1'b1;
                d.rt_rd = 1'b1;
                d.mem   = 1'b1;
            end
            6'd4, 6'd5: begin
                d.rs_rd = 1'b1;
                d.rt_rd = 1'b1;
                d.ctl   = 1'b1;
            end
            6'd2: d.ctl = 1'b1;
            6'd3: begin
                d.ctl = 1'b1;
                d.dst = 5'd31;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_stall;
    logic [31:0] r_hold_pc;
    logic [31:0] r_hold_instr;
    dec_t        w_d1;
    dec_t        w_d2;
    logic        w_raw;
    logic        w_waw;
    logic        w_split;
    logic [31:0] w_pc4;
    logic        w_unused;

    assign w_unused = ^{instr1_in[10:6], instr2_in[10:6]};

    assign w_d1  = f_dec(instr1_in);
    assign w_d2  = f_dec(instr2_in);
    assign w_pc4 = pc_in + 32'd4;

    // A dest of r0 is "no dest", so it can never create a RAW or WAW hazard.
    assign w_raw = (w_d1.dst != 5'd0) &&
                   ((w_d2.rs_rd && (w_d1.dst == instr2_in[25:21])) ||
                    (w_d2.rt_rd && (w_d1.dst == instr2_in[20:16])));
    assign w_waw   = (w_d1.dst != 5'd0) && (w_d1.dst == w_d2.dst);
    assign w_split = w_raw || w_waw || (w_d1.mem && w_d2.mem) || w_d1.ctl || w_d2.ctl;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_PAIR;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        if (reset || flush) begin
            w_state_nxt = ST_PAIR;
        end else begin
            case (r_state)
                ST_PAIR: begin
                    if (valid_in && w_split) begin
                        w_stall     = 1'b1;
                        w_state_nxt = ST_SECOND;
                    end
                end
                ST_SECOND: w_state_nxt = ST_PAIR;
                default:   w_state_nxt = ST_PAIR;
            endcase
        end
    end

    assign stall = w_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            slot0_pc     <= '0;
            slot0_instr  <= '0;
            slot0_valid  <= 1'b0;
            slot1_pc     <= '0;
            slot1_instr  <= '0;
            slot1_valid  <= 1'b0;
            r_hold_pc    <= '0;
            r_hold_instr <= '0;
        end else if (flush) begin
            slot0_valid  <= 1'b0;
            slot1_valid  <= 1'b0;
            r_hold_pc    <= '0;
            r_hold_instr <= '0;
        end else if (r_state == ST_SECOND) begin
            // Upstream is still presenting the split pair here; only the hold matters.
            slot0_pc    <= r_hold_pc;
            slot0_instr <= r_hold_instr;
            slot0_valid <= 1'b1;
            slot1_valid <= 1'b0;
        end else if (valid_in) begin
            slot0_pc    <= pc_in;
            slot0_instr <= instr1_in;
            slot0_valid <= 1'b1;
            if (w_split) begin
                slot1_valid  <= 1'b0;
                r_hold_pc    <= w_pc4;
                r_hold_instr <= instr2_in;
            end else begin
                slot1_pc    <= w_pc4;
                slot1_instr <= instr2_in;
                slot1_valid <= 1'b1;
            end
        end else begin
            slot0_valid <= 1'b0;
            slot1_valid <= 1'b0;
        end
    end

`ifdef ISSUE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pair_cnt  <= '0;
            split_cnt <= '0;
        end else if (!flush && (r_state == ST_PAIR) && valid_in) begin
            if (w_split) begin
                if (split_cnt != {CNT_W{1'b1}}) split_cnt <= split_cnt + 1'b1;
            end else begin
                if (pair_cnt != {CNT_W{1'b1}}) pair_cnt <= pair_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// tb/tb_dual_issue_ctrl.sv - self-checking bench for dual_issue_ctrl against a queue-based issue model
module tb_dual_issue_ctrl;

    localparam int TB_CNT_W = 2;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] instr1_in;
    logic [31:0] instr2_in;
    logic        valid_in;
    logic        flush;
    logic        stall;
    logic [31:0] slot0_pc;
    logic [31:0] slot0_instr;
    logic        slot0_valid;
    logic [31:0] slot1_pc;
    logic [31:0] slot1_instr;
    logic        slot1_valid;
`ifdef ISSUE_STATS_EN
    logic [TB_CNT_W-1:0] pair_cnt;
    logic [TB_CNT_W-1:0] split_cnt;
`endif

    dual_issue_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .instr1_in   (instr1_in),
        .instr2_in   (instr2_in),
        .valid_in    (valid_in),
        .flush       (flush),
        .stall       (stall),
        .slot0_pc    (slot0_pc),
        .slot0_instr (slot0_instr),
        .slot0_valid (slot0_valid),
        .slot1_pc    (slot1_pc),
        .slot1_instr (slot1_instr),
        .slot1_valid (slot1_valid)
`ifdef ISSUE_STATS_EN
        ,
        .pair_cnt    (pair_cnt),
        .split_cnt   (split_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Register usage expressed as a read mask, so RAW is a simple bit lookup.
    function automatic void dec(input logic [31:0] ins, output logic [4:0] dst,
                                output logic [31:0] rmask, output bit mem, output bit ctl);
        int op;
        op    = int'(ins[31:26]);
        dst   = 5'd0;
        rmask = '0;
        mem   = 1'b0;
        ctl   = 1'b0;
        if (op == 0) begin
            if (ins[5:0] == 6'h08) begin
                ctl = 1'b1;
                rmask[ins[25:21]] = 1'b1;
            end else begin
                dst = ins[15:11];
                rmask[ins[25:21]] = 1'b1;
                rmask[ins[20:16]] = 1'b1;
            end
        end else if (op >= 8 && op <= 15) begin
            dst = ins[20:16];
            rmask[ins[25:21]] = 1'b1;
        end else if (op == 35) begin
            dst = ins[20:16];
            rmask[ins[25:21]] = 1'b1;
            mem = 1'b1;
        end else if (op == 43) begin
            rmask[ins[25:21]] = 1'b1;
            rmask[ins[20:16]] = 1'b1;
            mem = 1'b1;
        end else if (op == 4 || op == 5) begin
            rmask[ins[25:21]] = 1'b1;
            rmask[ins[20:16]] = 1'b1;
            ctl = 1'b1;
        end else if (op == 2) begin
            ctl = 1'b1;
        end else if (op == 3) begin
            ctl = 1'b1;
            dst = 5'd31;
        end
    endfunction

    function automatic bit conflict(input logic [31:0] a, input logic [31:0] b);
        logic [4:0]  da, db;
        logic [31:0] ra, rb;
        bit          ma, mb, ca, cb;
        dec(a, da, ra, ma, ca);
        dec(b, db, rb, mb, cb);
        return ((da != 0) && rb[da]) || ((da != 0) && (da == db)) || (ma && mb) || ca || cb;
    endfunction

    // Model: a queue of instructions still owed to slot0 after a split.
    logic [63:0] pend[$];
    logic [31:0] e_s0_pc, e_s0_instr, e_s1_pc, e_s1_instr;
    logic        e_s0_v, e_s1_v;
    int          e_pair, e_split;
    bit          model_ok = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            pend.delete();
            {e_s0_pc, e_s0_instr, e_s1_pc, e_s1_instr} = '0;
            e_s0_v   = 1'b0;
            e_s1_v   = 1'b0;
            e_pair   = 0;
            e_split  = 0;
            model_ok = 1'b1;
        end else if (flush) begin
            pend.delete();
            e_s0_v = 1'b0;
            e_s1_v = 1'b0;
        end else if (pend.size() != 0) begin
            {e_s0_pc, e_s0_instr} = pend.pop_front();
            e_s0_v = 1'b1;
            e_s1_v = 1'b0;
        end else if (valid_in) begin
            e_s0_pc    = pc_in;
            e_s0_instr = instr1_in;
            e_s0_v     = 1'b1;
            if (conflict(instr1_in, instr2_in)) begin
                pend.push_back({pc_in + 32'd4, instr2_in});
                e_s1_v = 1'b0;
                e_split++;
            end else begin
                e_s1_pc    = pc_in + 32'd4;
                e_s1_instr = instr2_in;
                e_s1_v     = 1'b1;
                e_pair++;
            end
        end else begin
            e_s0_v = 1'b0;
            e_s1_v = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("m_stall", 64'(stall),
                64'(!reset && !flush && pend.size() == 0 && valid_in && conflict(instr1_in, instr2_in)));
            chk("m_slot0", {slot0_valid, slot0_pc, slot0_instr}, {e_s0_v, e_s0_pc, e_s0_instr});
            chk("m_slot1_v", 64'(slot1_valid), 64'(e_s1_v));
            if (e_s1_v) chk("m_slot1", {slot1_pc, slot1_instr}, {e_s1_pc, e_s1_instr});
`ifdef ISSUE_STATS_EN
            chk("m_pair_cnt", 64'(pair_cnt), 64'((e_pair > 3) ? 3 : e_pair));
            chk("m_split_cnt", 64'(split_cnt), 64'((e_split > 3) ? 3 : e_split));
`endif
        end
    end

    task automatic put(input logic v, input logic [31:0] pc, input logic [31:0] i1, input logic [31:0] i2);
        valid_in  = v;
        pc_in     = pc;
        instr1_in = i1;
        instr2_in = i2;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        put(1'b0, 32'h0, 32'h0, 32'h0);
        tick;
        tick;
        reset = 1'b0;
        chk("rst_slot0", {slot0_valid, slot0_pc, slot0_instr}, 64'h0);
        chk("rst_slot1", {slot1_valid, slot1_pc, slot1_instr}, 64'h0);
        chk("rst_stall", 64'(stall), 64'h0);

        // Memory conflict: lw + sw
        put(1'b1, 32'h300, 32'h8C290000, 32'hAC620004);
        #1 chk("mem_stall", 64'(stall), 64'h1);
        tick;
        chk("mem_s0a", {slot0_valid, slot0_pc, slot0_instr}, {1'b1, 32'h300, 32'h8C290000});
        chk("mem_s1v_a", 64'(slot1_valid), 64'h0);
        tick;
        chk("mem_s0b", {slot0_valid, slot0_pc, slot0_instr}, {1'b1, 32'h304, 32'hAC620004});
`ifdef ISSUE_STATS_EN
        chk("mem_split_cnt", 64'(split_cnt), 64'h1);
        chk("mem_pair_cnt", 64'(pair_cnt), 64'h0);
`endif

        // Independent pair
        put(1'b1, 32'h100, 32'h00221820, 32'h00E83020);
        #1 chk("ind_stall", 64'(stall), 64'h0);
        tick;
        chk("ind_s0", {slot0_valid, slot0_pc, slot0_instr}, {1'b1, 32'h100, 32'h00221820});
        chk("ind_s1", {slot1_valid, slot1_pc, slot1_instr}, {1'b1, 32'h104, 32'h00E83020});

        // RAW hazard
        put(1'b1, 32'h200, 32'h00221820, 32'h00642822);
        #1 chk("raw_stall", 64'(stall), 64'h1);
        tick;
        chk("raw_s0a", {slot0_valid, slot0_pc, slot0_instr}, {1'b1, 32'h200, 32'h00221820});
        chk("raw_s1v_a", 64'(slot1_valid), 64'h0);
        chk("raw_stall_second", 64'(stall), 64'h0);
        tick;
        chk("raw_s0b", {slot0_valid, slot0_pc, slot0_instr}, {1'b1, 32'h204, 32'h00642822});
        chk("raw_s1v_b", 64'(slot1_valid), 64'h0);

        // Control transfer then flush during SECOND
        put(1'b1, 32'h400, 32'h10220001, 32'h00E83020);
        tick;
        flush = 1'b1;
        #1 chk("flush_stall", 64'(stall), 64'h0);
        tick;
        flush = 1'b0;
        put(1'b0, 32'h0, 32'h0, 32'h0);
        chk("flush_valids", {slot0_valid, slot1_valid}, 64'h0);
        tick;
        chk("flush_no_hold", {slot0_valid, slot1_valid}, 64'h0);

        // Reset while in SECOND
        put(1'b1, 32'h500, 32'h00221820, 32'h00642822);
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("rmid_s0", {slot0_valid, slot0_pc, slot0_instr}, 64'h0);
        chk("rmid_s1", {slot1_valid, slot1_pc, slot1_instr}, 64'h0);
        put(1'b1, 32'h600, 32'h00221820, 32'h00E83020);
        tick;
        chk("rmid_dual", {slot0_valid, slot1_valid, slot1_pc}, {1'b1, 1'b1, 32'h604});

        // PC wrap and all-zero instructions
        put(1'b1, 32'hFFFF_FFFC, 32'h00221820, 32'h00E83020);
        tick;
        chk("wrap_s1_pc", {slot1_valid, slot1_pc}, {1'b1, 32'h0});
        put(1'b1, 32'h700, 32'h0, 32'h0);
        tick;
        chk("zero_dual", {slot0_valid, slot1_valid}, 64'h3);

        // WAW: add $3 + addi $3,$5,1
        put(1'b1, 32'h800, 32'h00221820, 32'h20A30001);
        #1 chk("waw_stall", 64'(stall), 64'h1);
        tick;
        put(1'b0, 32'h0, 32'h0, 32'h0);
        tick;
        chk("waw_s0b", {slot0_valid, slot0_pc, slot0_instr}, {1'b1, 32'h804, 32'h20A30001});

        // Five independent pairs drive the pair counter into saturation
        for (int k = 0; k < 5; k++) begin
            put(1'b1, 32'h900 + 32'(k * 8), 32'h00221820, 32'h00E83020);
            tick;
        end
`ifdef ISSUE_STATS_EN
        chk("sat_pair_cnt", 64'(pair_cnt), 64'h3);
`endif
        put(1'b0, 32'h0, 32'h0, 32'h0);
        tick;
        tick;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dual_issue_ctrl.md
# dual_issue_ctrl

Dual-issue pairing/split controller sitting directly downstream of the dual IF/ID pipeline register. Each cycle it consumes the fetched pair (pc, instr1, instr2), checks intra-pair hazards and structural conflicts, and drives two registered issue slots into the dual decode/execute path. When the pair cannot issue together, it issues instr1 alone, holds instr2 internally for one cycle, and stalls fetch so the upstream register holds.

## Interface
- CNT_W, 32: width of the statistics counters (used only with ISSUE_STATS_EN).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- pc_in  in  32  PC of instr1; instr2 is at pc_in+4.
- instr1_in  in  32  first instruction of the pair.
- instr2_in  in  32  second instruction of the pair.
- valid_in  in  1  the pair on the inputs is valid.
- flush  in  1  taken branch/jump resolved downstream; kill issued and held work.
- stall  out  1  combinational; upstream PC and IF/ID register must hold this cycle.
- slot0_pc / slot0_instr  out  32/32  older issued instruction.
- slot0_valid  out  1
- slot1_pc / slot1_instr  out  32/32  younger issued instruction.
- slot1_valid  out  1
- pair_cnt, split_cnt  out  CNT_W each  only with ISSUE_STATS_EN.

## Operation
- Decode per instruction (op = [31:26]):
  - R-type (op 0): dest rd [15:11], srcs rs, rt; funct 0x08 (jr) is a control transfer with no dest.
  - I-ALU (op 8–15): dest rt, src rs.
  - lw (35): dest rt, src rs, mem.
  - sw (43): srcs rs, rt, mem, no dest.
  - beq/bne (4/5): srcs rs, rt, control.
  - j (2): control, no regs. jal (3): control, dest r31.
  - Any other op: no dest, no srcs.
  - Dest r0 counts as no dest.
- A split is required if any of the following holds:
  - RAW: instr1 dest equals an instr2 source.
  - WAW: both instructions have the same dest.
  - Both instructions are mem ops.
  - Either instruction is a control transfer.
- FSM has two states: PAIR (reset) and SECOND.
- PAIR, valid_in=0:
  - Both slot valids are cleared at the edge.
- PAIR, valid_in=1, no split:
  - slot0 gets {pc_in, instr1}; slot1 gets {pc_in+4, instr2}.
  - Both valids set; remain in PAIR.
- PAIR, valid_in=1, split:
  - stall=1.
  - slot0 gets {pc_in, instr1}; slot1_valid=0.
  - Capture instr2 and pc_in+4 into hold registers; go to SECOND.
- SECOND:
  - stall=0; inputs are ignored.
  - slot0 gets the held pair; slot1_valid=0; go to PAIR.
- Priority is reset > flush > normal.
- flush (either state): at the edge, both valids are cleared, the hold is discarded, the state returns to PAIR, and stall is forced to 0 in that cycle.
- pc_in+4 is computed modulo 2^32.
- Output pc/instr fields retain their last value when not loaded.

## Timing
- Issue latency is one cycle from input pair to slot outputs.
- Split timing:
  - Cycle N: pair A with a conflict; stall=1.
  - Cycle N+1: slot0 = A.instr1; state SECOND; upstream still presents A (ignored).
  - Cycle N+2: slot0 = A.instr2; pair B is accepted.
- Throughput is 2 instructions/cycle without conflicts and 2 per 2 cycles on a split.
- Reset: all slot outputs 0, valids 0, stall 0, state PAIR, hold registers 0, counters 0.
- Reset or flush asserted while in SECOND: the held instr2 is never issued.
- The all-zero instruction (sll r0) has dest r0, so it never causes a conflict and issues as valid.

## Configuration
- ISSUE_STATS_EN defined:
  - pair_cnt increments on each dual issue.
  - split_cnt increments on each split detection.
  - Both counters saturate at 2^CNT_W-1 and clear on reset only, not on flush.
- ISSUE_STATS_EN undefined:
  - The ports and counters are absent.
  - All other behaviour is identical.

## Test plan
- Independent pair: pc=0x100, add $3,$1,$2 (0x00221820) + add $6,$7,$8 (0x00E83020) → next cycle slot0 {0x100, 0x00221820}, slot1 {0x104, 0x00E83020}, both valid, stall 0.
- RAW: 0x00221820 + sub $5,$3,$4 (0x00642822) at pc=0x200 → stall=1 for one cycle; slot0 0x00221820 then slot0 {0x204, 0x00642822}; slot1_valid 0 both cycles.
- Mem conflict: lw $9,0($1) (0x8C290000) + sw $2,4($3) (0xAC620004) → split; with ISSUE_STATS_EN, split_cnt=1 and pair_cnt=0.
- Control: beq (0x10220001) in instr1 followed by flush in the SECOND cycle → held instr2 never issued; valids 0; state PAIR.
- Reset mid-split: reset asserted in the SECOND cycle → all outputs 0 next edge; the following independent pair issues dual normally.
- Counter saturation with CNT_W=2: 5 independent pairs → pair_cnt stays 3.
